// File: rtl/mac_pkg.sv
// rtl/mac_pkg.sv - shared limits, counter sizing and operand extension for the dot-product MAC
package mac_pkg;

    localparam int MAX_W = 64;
    typedef logic [MAX_W-1:0] wide_t;

    function automatic wide_t acc_max(input int acc_w, input bit is_signed);
        return (wide_t'(1) << (acc_w - (is_signed ? 1 : 0))) - wide_t'(1);
    endfunction

    // Returned sign-extended to MAX_W; callers truncate to their accumulator width.
    function automatic wide_t acc_min(input int acc_w, input bit is_signed);
        return is_signed ? ~acc_max(acc_w, 1'b1) : '0;
    endfunction

    function automatic int cnt_w(input int len);
        return (len > 1) ? $clog2(len) : 1;
    endfunction

    function automatic wide_t ext(input wide_t v, input int src_w, input bit is_signed);
        wide_t r;
        r = v << (MAX_W - src_w);
        if (is_signed) begin
            r = $unsigned($signed(r) >>> (MAX_W - src_w));
        end else begin
            r = r >> (MAX_W - src_w);
        end
        return r;
    endfunction

endpackage

// File: rtl/pipelined_dot_mac_if.sv
// rtl/pipelined_dot_mac_if.sv - operand and result handshake bundle for the dot-product MAC
interface pipelined_dot_mac_if #(
    parameter int WIDTH = 8,
    parameter int ACC_W = 2 * WIDTH + 4
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_data;
    logic             out_ovf;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, out_data, out_ovf
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, out_data, out_ovf
    );
endinterface

// File: rtl/mac_sat_add.sv
// rtl/mac_sat_add.sv - combinational accumulator adder with overflow detect and optional clamp
module mac_sat_add
    import mac_pkg::*;
#(
    parameter int ACC_W    = 20,
    parameter bit SIGNED   = 1'b1,
    parameter bit SATURATE = 1'b1
) (
    input  logic [ACC_W-1:0] a_i,
    input  logic [ACC_W-1:0] b_i,
    output logic [ACC_W-1:0] sum_o,
    output logic             ovf_o
);
    localparam logic [ACC_W-1:0] SAT_MAX = ACC_W'(acc_max(ACC_W, SIGNED));
    localparam logic [ACC_W-1:0] SAT_MIN = ACC_W'(acc_min(ACC_W, SIGNED));

    logic [ACC_W:0] raw;

    assign raw = {1'b0, a_i} + {1'b0, b_i};

    always_comb begin
        // Signed overflow: like-signed operands producing a result of the other sign.
        ovf_o = SIGNED ? ((a_i[ACC_W-1] == b_i[ACC_W-1]) && (raw[ACC_W-1] != a_i[ACC_W-1]))
                       : raw[ACC_W];
        sum_o = raw[ACC_W-1:0];
        if (SATURATE && ovf_o) begin
            sum_o = (SIGNED && a_i[ACC_W-1]) ? SAT_MIN : SAT_MAX;
        end
    end
endmodule

// File: rtl/pipelined_dot_mac.sv
// rtl/pipelined_dot_mac.sv - two-stage multiply then accumulate, one result per LEN accepted terms
module pipelined_dot_mac
    import mac_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int LEN      = 4,
    parameter int ACC_W    = 2 * WIDTH + 4,
    parameter bit SIGNED   = 1'b1,
    parameter bit SATURATE = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    pipelined_dot_mac_if.slave bus
);
    localparam int              PW       = 2 * WIDTH;
    localparam int              CNT_W    = cnt_w(LEN);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LEN - 1);

    logic             en;
    logic             accept;
    logic [PW-1:0]    mul;
    logic [ACC_W-1:0] prod_ext;
    logic [ACC_W-1:0] sum;
    logic             add_ovf;

    logic             s1_valid_q, s1_valid_d;
    logic [PW-1:0]    prod_q, prod_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sticky_q, sticky_d;
    logic             out_valid_q, out_valid_d;
    logic [ACC_W-1:0] out_data_q, out_data_d;
    logic             out_ovf_q, out_ovf_d;

    // A stalled result freezes the whole pipe; clr also refuses new operands.
    assign en           = !(out_valid_q && !bus.out_ready);
    assign bus.in_ready = en && !clr;
    assign accept       = bus.in_valid && bus.in_ready;

    assign mul = SIGNED
        ? PW'($signed({{WIDTH{bus.a[WIDTH-1]}}, bus.a}) * $signed({{WIDTH{bus.b[WIDTH-1]}}, bus.b}))
        : PW'({{WIDTH{1'b0}}, bus.a} * {{WIDTH{1'b0}}, bus.b});

    assign prod_ext = ACC_W'(ext(wide_t'(prod_q), PW, SIGNED));

    mac_sat_add #(
        .ACC_W    (ACC_W),
        .SIGNED   (SIGNED),
        .SATURATE (SATURATE)
    ) u_add (
        .a_i   (acc_q),
        .b_i   (prod_ext),
        .sum_o (sum),
        .ovf_o (add_ovf)
    );

    always_comb begin
        s1_valid_d  = s1_valid_q;
        prod_d      = prod_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        sticky_d    = sticky_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ovf_d   = out_ovf_q;
        if (clr) begin
            s1_valid_d  = 1'b0;
            acc_d       = '0;
            cnt_d       = '0;
            sticky_d    = 1'b0;
            out_valid_d = 1'b0;
            out_ovf_d   = 1'b0;
        end else if (en) begin
            if (out_valid_q && bus.out_ready) begin
                out_valid_d = 1'b0;
            end
            s1_valid_d = accept;
            if (accept) begin
                prod_d = mul;
            end
            if (s1_valid_q) begin
                if (cnt_q == CNT_LAST) begin
                    out_data_d  = sum;
                    out_ovf_d   = sticky_q | add_ovf;
                    out_valid_d = 1'b1;
                    acc_d       = '0;
                    cnt_d       = '0;
                    sticky_d    = 1'b0;
                end else begin
                    acc_d    = sum;
                    cnt_d    = cnt_q + CNT_W'(1);
                    sticky_d = sticky_q | add_ovf;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            prod_q      <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            sticky_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ovf_q   <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            prod_q      <= prod_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            sticky_q    <= sticky_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_ovf   = out_ovf_q;
endmodule

// File: tb/tb_pipelined_dot_mac.sv
// tb/tb_pipelined_dot_mac.sv - four-configuration bench with a term-level dot-product reference model
module tb_pipelined_dot_mac;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clr = 1'b0;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b1;
    logic [7:0] a = '0;
    logic [7:0] b = '0;

    always #5 clk = ~clk;

    pipelined_dot_mac_if #(.WIDTH(8), .ACC_W(20)) if0 ();
    pipelined_dot_mac_if #(.WIDTH(8), .ACC_W(20)) if1 ();
    pipelined_dot_mac_if #(.WIDTH(8), .ACC_W(16)) if2 ();
    pipelined_dot_mac_if #(.WIDTH(8), .ACC_W(16)) if3 ();

    assign {if0.in_valid, if1.in_valid, if2.in_valid, if3.in_valid} = {4{in_valid}};
    assign {if0.out_ready, if1.out_ready, if2.out_ready, if3.out_ready} = {4{out_ready}};
    assign {if0.a, if1.a, if2.a, if3.a} = {4{a}};
    assign {if0.b, if1.b, if2.b, if3.b} = {4{b}};

    pipelined_dot_mac #(.WIDTH(8), .LEN(4), .ACC_W(20), .SIGNED(1), .SATURATE(1)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .bus(if0.slave));
    pipelined_dot_mac #(.WIDTH(8), .LEN(4), .ACC_W(20), .SIGNED(0), .SATURATE(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .bus(if1.slave));
    pipelined_dot_mac #(.WIDTH(8), .LEN(4), .ACC_W(16), .SIGNED(1), .SATURATE(1)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .bus(if2.slave));
    pipelined_dot_mac #(.WIDTH(8), .LEN(4), .ACC_W(16), .SIGNED(1), .SATURATE(0)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .bus(if3.slave));

    int cfg_w   [4] = '{20, 20, 16, 16};
    bit cfg_s   [4] = '{1, 0, 1, 1};
    bit cfg_sat [4] = '{1, 1, 1, 0};

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int n_acc = 0;
    int last_acc_cyc = 0;
    bit last_acc = 1'b0;

    logic [7:0]  pa[$];
    logic [7:0]  pb[$];
    logic [31:0] gd [4][$];
    bit          go [4][$];
    int          gcyc[$];
    logic [31:0] ed [4][$];
    bit          eo [4][$];

    // Dot product of the LEN terms in pa/pb with exact integer arithmetic, then clamped or wrapped.
    function automatic logic [32:0] model(input int i);
        longint m, mx, mn, acc, sa, sb, sum;
        bit ovf;
        m   = longint'(1) << cfg_w[i];
        mx  = cfg_s[i] ? m / 2 - 1 : m - 1;
        mn  = cfg_s[i] ? -(m / 2) : 0;
        acc = 0;
        ovf = 1'b0;
        for (int k = 0; k < pa.size(); k++) begin
            sa  = cfg_s[i] ? longint'($signed(pa[k])) : longint'(pa[k]);
            sb  = cfg_s[i] ? longint'($signed(pb[k])) : longint'(pb[k]);
            sum = acc + sa * sb;
            if (sum > mx || sum < mn) begin
                ovf = 1'b1;
                if (cfg_sat[i]) begin
                    sum = (sum > mx) ? mx : mn;
                end else begin
                    sum = ((sum % m) + m) % m;
                    if (sum > mx) sum = sum - m;
                end
            end
            acc = sum;
        end
        return {ovf, 32'(acc & (m - 1))};
    endfunction

    task automatic flush();
        pa.delete();
        pb.delete();
        gcyc.delete();
        for (int i = 0; i < 4; i++) begin
            gd[i].delete(); go[i].delete(); ed[i].delete(); eo[i].delete();
        end
        n_acc = 0;
    endtask

    task automatic step();
        logic [32:0] r;
        @(negedge clk);
        last_acc = in_valid && if0.in_ready;
        if (last_acc) begin
            n_acc++;
            last_acc_cyc = cyc;
            pa.push_back(a);
            pb.push_back(b);
            if (pa.size() == 4) begin
                for (int i = 0; i < 4; i++) begin
                    r = model(i);
                    ed[i].push_back(r[31:0]);
                    eo[i].push_back(r[32]);
                end
                pa.delete();
                pb.delete();
            end
        end
        if (if0.out_valid && out_ready) begin
            gd[0].push_back(32'(if0.out_data)); go[0].push_back(if0.out_ovf); gcyc.push_back(cyc);
        end
        if (if1.out_valid && out_ready) begin
            gd[1].push_back(32'(if1.out_data)); go[1].push_back(if1.out_ovf);
        end
        if (if2.out_valid && out_ready) begin
            gd[2].push_back(32'(if2.out_data)); go[2].push_back(if2.out_ovf);
        end
        if (if3.out_valid && out_ready) begin
            gd[3].push_back(32'(if3.out_data)); go[3].push_back(if3.out_ovf);
        end
        if (clr) begin
            pa.delete();
            pb.delete();
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic send(input logic [7:0] av, input logic [7:0] bv);
        int t;
        t = 0;
        in_valid = 1'b1;
        a = av;
        b = bv;
        do begin
            step();
            t++;
        end while (!last_acc && t < 50);
        if (!last_acc) begin
            n_vec++; n_err++;
            $display("FAIL send_timeout: term a=%0d b=%0d not accepted within %0d cycles", av, bv, t);
        end
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) step();
    endtask

    task automatic test_reset();
        in_valid = 1'b0; out_ready = 1'b1; rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_vec++;
        if (if0.out_valid !== 1'b0 || if0.out_data !== 20'd0 || if0.out_ovf !== 1'b0) begin
            n_err++;
            $display("FAIL reset_state: valid=%b data=%0d ovf=%b, required 0/0/0", if0.out_valid, if0.out_data, if0.out_ovf);
        end
        rst_n = 1'b1;
        #1;
        n_vec++;
        if (if0.in_ready !== 1'b1) begin
            n_err++; $display("FAIL reset_in_ready: in_ready=%b, required 1", if0.in_ready);
        end
        out_ready = 1'b0;
        repeat (4) send(8'd127, 8'd127);
        idle(4);
        n_vec++;
        if (if0.out_valid !== 1'b1 || if0.out_data !== 20'd64516 || if2.out_ovf !== 1'b1) begin
            n_err++;
            $display("FAIL reset_pending: valid=%b data=%0d ovf16=%b, required 1/64516/1", if0.out_valid, if0.out_data, if2.out_ovf);
        end
        #2 rst_n = 1'b0;
        #1;
        n_vec++;
        if (if0.out_valid !== 1'b0 || if0.out_data !== 20'd0 || if2.out_ovf !== 1'b0 || if2.out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL async_reset: valid=%b data=%0d ovf16=%b, required 0/0/0", if0.out_valid, if0.out_data, if2.out_ovf);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        n_vec++;
        if (if0.in_ready !== 1'b1) begin
            n_err++; $display("FAIL release_in_ready: in_ready=%b, required 1", if0.in_ready);
        end
        out_ready = 1'b1;
        flush();
    endtask

    task automatic test_basic();
        int t_first;
        int t_second;
        flush();
        out_ready = 1'b1;
        repeat (4) send(8'd3, 8'd4);
        t_first = last_acc_cyc;
        repeat (4) send(8'd1, 8'd2);
        t_second = last_acc_cyc;
        idle(8);
        n_vec++;
        if (gd[0].size() != 2) begin
            n_err++; $display("FAIL basic_count: %0d results, required 2", gd[0].size());
        end else begin
            n_vec++;
            if (gd[0][0] !== 32'd48 || go[0][0] !== 1'b0) begin
                n_err++; $display("FAIL basic_first: data=%0d ovf=%b, required 48/0", gd[0][0], go[0][0]);
            end
            n_vec++;
            if (gcyc[0] - t_first != 2) begin
                n_err++; $display("FAIL basic_latency: %0d cycles after last accept, required 2", gcyc[0] - t_first);
            end
            n_vec++;
            if (gd[0][1] !== 32'd8 || gcyc[1] - gcyc[0] != 4 || gcyc[1] - t_second != 2) begin
                n_err++; $display("FAIL basic_back_to_back: data=%0d gap=%0d, required 8/4", gd[0][1], gcyc[1] - gcyc[0]);
            end
        end
    endtask

    task automatic test_signed();
        flush();
        out_ready = 1'b1;
        repeat (4) send(8'hFB, 8'd7);
        repeat (4) send(8'hFF, 8'hFF);
        idle(6);
        n_vec++;
        if (gd[0].size() != 2 || gd[1].size() != 2) begin
            n_err++; $display("FAIL signed_count: %0d/%0d results, required 2/2", gd[0].size(), gd[1].size());
        end else begin
            n_vec++;
            if (gd[0][0] !== 32'hFFF74 || gd[0][1] !== 32'd4) begin
                n_err++; $display("FAIL signed_data: %h %0d, required fff74 4", gd[0][0], gd[0][1]);
            end
            n_vec++;
            if (gd[1][1] !== 32'd260100 || go[1][1] !== 1'b0) begin
                n_err++; $display("FAIL unsigned_data: %0d ovf=%b, required 260100/0", gd[1][1], go[1][1]);
            end
        end
    endtask

    task automatic test_backpressure();
        int n2;
        flush();
        out_ready = 1'b0;
        repeat (4) send(8'd3, 8'd4);
        in_valid = 1'b1; a = 8'd2; b = 8'd2;
        n2 = 0;
        for (int s = 0; s < 6; s++) begin
            step();
            if (last_acc) n2++;
            if (s >= 1) begin
                n_vec++;
                if (if0.in_ready !== 1'b0 || if0.out_valid !== 1'b1 || if0.out_data !== 20'd48) begin
                    n_err++;
                    $display("FAIL bp_hold: in_ready=%b valid=%b data=%0d, required 0/1/48", if0.in_ready, if0.out_valid, if0.out_data);
                end
            end
        end
        out_ready = 1'b1;
        for (int s = 0; s < 40 && n2 < 4; s++) begin
            step();
            if (last_acc) n2++;
        end
        idle(8);
        n_vec++;
        if (n_acc != 8 || gd[0].size() != 2) begin
            n_err++; $display("FAIL bp_terms: accepted=%0d results=%0d, required 8/2", n_acc, gd[0].size());
        end else begin
            n_vec++;
            if (gd[0][0] !== 32'd48 || gd[0][1] !== 32'd16) begin
                n_err++; $display("FAIL bp_data: %0d %0d, required 48 16", gd[0][0], gd[0][1]);
            end
        end
    endtask

    task automatic test_saturation();
        flush();
        out_ready = 1'b1;
        repeat (4) send(8'd127, 8'd127);
        repeat (4) send(8'd1, 8'd1);
        idle(6);
        n_vec++;
        if (gd[2].size() != 2 || gd[3].size() != 2 || gd[0].size() != 2) begin
            n_err++; $display("FAIL sat_count: %0d/%0d results, required 2/2", gd[2].size(), gd[3].size());
        end else begin
            n_vec++;
            if (gd[2][0] !== 32'd32767 || go[2][0] !== 1'b1) begin
                n_err++; $display("FAIL sat_clamp: data=%0d ovf=%b, required 32767/1", gd[2][0], go[2][0]);
            end
            n_vec++;
            if (gd[2][1] !== 32'd4 || go[2][1] !== 1'b0) begin
                n_err++; $display("FAIL sat_sticky_clear: data=%0d ovf=%b, required 4/0", gd[2][1], go[2][1]);
            end
            n_vec++;
            if (gd[3][0] !== 32'hFC04 || go[3][0] !== 1'b1 || gd[3][1] !== 32'd4 || go[3][1] !== 1'b0) begin
                n_err++; $display("FAIL wrap: %h/%b %0d/%b, required fc04/1 4/0", gd[3][0], go[3][0], gd[3][1], go[3][1]);
            end
            n_vec++;
            if (gd[0][0] !== 32'd64516 || go[0][0] !== 1'b0) begin
                n_err++; $display("FAIL wide_no_ovf: data=%0d ovf=%b, required 64516/0", gd[0][0], go[0][0]);
            end
        end
    endtask

    task automatic test_clear();
        flush();
        out_ready = 1'b1;
        repeat (2) send(8'd5, 8'd5);
        idle(2);
        clr = 1'b1; in_valid = 1'b1; a = 8'd9; b = 8'd9;
        #1;
        n_vec++;
        if (if0.in_ready !== 1'b0) begin
            n_err++; $display("FAIL clr_in_ready: in_ready=%b, required 0", if0.in_ready);
        end
        step();
        n_vec++;
        if (last_acc !== 1'b0) begin
            n_err++; $display("FAIL clr_accept: operand accepted during clr");
        end
        clr = 1'b0;
        repeat (4) send(8'd1, 8'd1);
        idle(6);
        n_vec++;
        if (gd[0].size() != 1 || gd[0][0] !== 32'd4) begin
            n_err++; $display("FAIL clr_result: %0d results first=%0d, required 1 result of 4", gd[0].size(), gd[0].size() ? gd[0][0] : 0);
        end
        flush();
        repeat (2) send(8'd5, 8'd5);
        idle(2);
        #2 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        pa.delete(); pb.delete();
        repeat (4) send(8'd1, 8'd1);
        idle(6);
        n_vec++;
        if (gd[0].size() != 1 || gd[0][0] !== 32'd4) begin
            n_err++; $display("FAIL rst_result: %0d results first=%0d, required 1 result of 4", gd[0].size(), gd[0].size() ? gd[0][0] : 0);
        end
    endtask

    task automatic test_random();
        flush();
        for (int s = 0; s < 300; s++) begin
            in_valid  = ($urandom_range(0, 9) < 8);
            a         = 8'($urandom);
            b         = 8'($urandom);
            out_ready = ($urandom_range(0, 9) < 7);
            step();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        idle(8);
        for (int i = 0; i < 4; i++) begin
            n_vec++;
            if (gd[i].size() != ed[i].size()) begin
                n_err++; $display("FAIL rand_count[%0d]: %0d results, required %0d", i, gd[i].size(), ed[i].size());
            end else begin
                for (int k = 0; k < gd[i].size(); k++) begin
                    n_vec++;
                    if (gd[i][k] !== ed[i][k] || go[i][k] !== eo[i][k]) begin
                        n_err++;
                        $display("FAIL rand_result[%0d][%0d]: data=%h ovf=%b, required %h/%b", i, k, gd[i][k], go[i][k], ed[i][k], eo[i][k]);
                    end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_signed();
        test_backpressure();
        test_saturation();
        test_clear();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/pipelined_dot_mac.md
Name: pipelined_dot_mac

Overview:
- Parametrised successor to the team's two-stage multiply-accumulate block.
- Computes signed or unsigned dot products of LEN term pairs (a_i*b_i), then emits one result per LEN accepted terms and restarts accumulation with no bubble.
- Adds valid/ready handshakes on input and output, backpressure, optional saturation with an overflow flag, and a synchronous clear.
- Sits between a streaming operand source (filter taps, matrix rows) and a result consumer.

Parameters:
WIDTH, 8, operand width of a and b
LEN, 4, terms per dot product (>=1)
ACC_W, 2*WIDTH+4, accumulator/result width (>=2*WIDTH+1)
SIGNED, 1, 1 = two's-complement operands and accumulation, 0 = unsigned
SATURATE, 1, 1 = clamp accumulation at ACC_W limits, 0 = wrap

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
clr  input  1  synchronous clear, flushes all in-flight state
in_valid  input  1  a/b valid
in_ready  output  1  block accepts a/b this cycle
a  input  WIDTH  operand A
b  input  WIDTH  operand B
out_valid  output  1  out_data/out_ovf valid
out_ready  input  1  consumer accepts result
out_data  output  ACC_W  dot-product result
out_ovf  output  1  overflow occurred during this dot product

Behaviour:
- Reset (rst_n=0, async): out_valid=0, out_data=0, out_ovf=0, stage-1 valid=0, product reg=0, acc=0, term count=0. in_ready is 1 after reset.
- Enable: en = !(out_valid && !out_ready); in_ready = en. This is a combinational path from out_ready to in_ready and is intended. When en=0, every register holds.
- Stage 1: when in_valid && in_ready, the product register loads a*b, which is 2*WIDTH wide and signed or unsigned per SIGNED, and s1_valid is set. If in_valid is low and en=1, s1_valid is cleared.
- Stage 2: when s1_valid && en, sum = acc + ext(product). ext sign-extends when SIGNED=1 and zero-extends otherwise.
  - cnt < LEN-1: acc <= sum, cnt++.
  - cnt == LEN-1: out_data <= sum, out_ovf <= ovf_sticky | this-add overflow, out_valid <= 1, acc <= 0, cnt <= 0, ovf_sticky <= 0.
- Overflow rules:
  - SATURATE=1: sum clamps to the ACC_W max/min (signed) or 0/max (unsigned).
  - SATURATE=0: sum wraps.
  - In both modes, ovf_sticky is set on any overflowing add.
- Output handshake: out_valid clears on out_ready unless a new result loads in the same cycle. A load in the same cycle as out_ready=1 is legal and replaces the result without a gap.
- Latency: the last term is accepted in cycle t, the product is registered at t+1, and out_valid is asserted at t+2. Full throughput is one term per cycle when out_ready=1.
- LEN=1: every accepted term yields one result.
- clr=1 (sync, below rst_n in priority): clears s1_valid, acc, cnt, ovf_sticky, out_valid, out_ovf. out_data holds. Operands presented during clr are not accepted: in_ready=0 while clr=1.
- Reset or clr mid-operation discards the partial sum. No partial result is ever emitted.

Decomposition:
- Package mac_pkg:
  - function acc_max/acc_min(ACC_W, SIGNED)
  - localparam CNT_W = $clog2(LEN) (min 1)
  - the ext() sign/zero-extension function
- One sub-module, mac_sat_add: a combinational ACC_W adder with SIGNED/SATURATE parameters that returns sum and an ovf flag. It is instantiated once in stage 2.

Test Plan:
All scenarios use WIDTH=8, LEN=4, SIGNED=1, SATURATE=1, ACC_W=20 unless stated.
1. Reset check: assert rst_n=0 mid-cycle -> out_valid=0, out_data=0, out_ovf=0 immediately; after release, in_ready=1.
2. Basic dot product: four consecutive terms a=3, b=4 with out_ready=1 -> out_valid for one cycle, out_data=48, out_ovf=0, two cycles after the 4th accept. Back-to-back second vector a=1, b=2 x4 -> out_data=8 exactly 4 cycles later.
3. Signed operands: a=-5, b=7 x4 -> out_data=-140 (20'hFFF74). Separately, SIGNED=0 with a=8'hFF, b=8'hFF x4 -> 260100.
4. Backpressure: hold out_ready=0 after result 48 -> in_ready=0, out_data stable, no term lost. Raise out_ready while four more terms a=2, b=2 are queued -> 48 consumed, then 16 delivered; total accepted terms is exactly 8.
5. Saturation: ACC_W=16, a=127, b=127 x4 -> out_data=32767, out_ovf=1. Next vector a=1, b=1 x4 -> out_data=4, out_ovf=0 (sticky flag cleared). With SATURATE=0, the same first vector -> out_data=64516 mod 2^16 as signed (-1020), out_ovf=1.
6. Clear and reset mid-operation: accept 2 terms, pulse clr -> no out_valid. Then a=1, b=1 x4 -> out_data=4. Repeat the sequence with rst_n pulsed instead of clr -> same result.
